// File: rtl/seqdet_pkg.sv
// Shared widths, defaults and slot layout for the multi-pattern serial sequence detector.
// Optional per-bit compare masks are enabled with SEQDET_MASK_EN.
package seqdet_pkg;

    localparam int DEF_MAX_LEN = 16;
    localparam int DEF_NUM_PAT = 4;
    localparam int DEF_CNT_W   = 8;

    function automatic int len_w(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // A single slot still needs a 1-bit select so the port is never zero-width.
    function automatic int sel_w(input int num_pat);
        return (num_pat > 1) ? $clog2(num_pat) : 1;
    endfunction

    localparam int DEF_LEN_W = len_w(DEF_MAX_LEN);

    typedef struct packed {
        logic [DEF_MAX_LEN-1:0] pat;
        logic [DEF_LEN_W-1:0]   len;
`ifdef SEQDET_MASK_EN
        logic [DEF_MAX_LEN-1:0] mask;
`endif
    } slot_t;

    localparam logic [DEF_CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/seqdet_if.sv
// Bit stream, configuration and match report bundle of the sequence detector.
// cfg_mask exists only when SEQDET_MASK_EN is defined.
interface seqdet_if #(
    parameter int MAX_LEN = seqdet_pkg::DEF_MAX_LEN,
    parameter int NUM_PAT = seqdet_pkg::DEF_NUM_PAT,
    parameter int CNT_W   = seqdet_pkg::DEF_CNT_W
);
    import seqdet_pkg::*;

    localparam int LEN_W = len_w(MAX_LEN);
    localparam int SEL_W = sel_w(NUM_PAT);

    logic               ena;
    logic               bit_in;
    logic               bit_valid;
    logic               cfg_we;
    logic [SEL_W-1:0]   cfg_sel;
    logic [MAX_LEN-1:0] cfg_pat;
    logic [LEN_W-1:0]   cfg_len;
`ifdef SEQDET_MASK_EN
    logic [MAX_LEN-1:0] cfg_mask;
`endif
    logic               cfg_overlap;
    logic               match;
    logic [SEL_W-1:0]   match_id;
    logic [CNT_W-1:0]   match_cnt;

    modport master (
        output ena, bit_in, bit_valid, cfg_we, cfg_sel, cfg_pat, cfg_len,
`ifdef SEQDET_MASK_EN
        output cfg_mask,
`endif
        output cfg_overlap,
        input  match, match_id, match_cnt
    );

    modport slave (
        input  ena, bit_in, bit_valid, cfg_we, cfg_sel, cfg_pat, cfg_len,
`ifdef SEQDET_MASK_EN
        input  cfg_mask,
`endif
        input  cfg_overlap,
        output match, match_id, match_cnt
    );

endinterface

// File: rtl/seqdet_cmp.sv
// Per-slot pattern comparator against the next-state window (SEQDET_MASK_EN adds a don't-care mask).
// Latency: purely combinational.
// Backpressure: none; the caller qualifies hit with a valid bit.
module seqdet_cmp
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = len_w(DEF_MAX_LEN)
) (
    input  logic [MAX_LEN-1:0] window,
    input  logic [LEN_W-1:0]   fill,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   len,
`ifdef SEQDET_MASK_EN
    input  logic [MAX_LEN-1:0] mask,
`endif
    output logic               hit
);

    logic [MAX_LEN-1:0] lenmask;
    logic [MAX_LEN-1:0] care;
    logic               len_ok;

    always_comb begin
        lenmask = '0;
        for (int b = 0; b < MAX_LEN; b++) begin
            lenmask[b] = (b < int'(len));
        end
`ifdef SEQDET_MASK_EN
        care = lenmask & mask;
`else
        care = lenmask;
`endif
        len_ok = (len != '0) && (int'(len) <= MAX_LEN);
        // An all-don't-care slot would match on every bit, so it is treated as disabled.
        hit = len_ok && (fill >= len) && (((window ^ pat) & care) == '0) && (care != '0);
    end

endmodule

// File: rtl/seq_detector_multi.sv
// Multi-pattern serial sequence detector with overlap/non-overlap modes (mask option: SEQDET_MASK_EN).
// Latency: match/match_id registered, one cycle after the final matching bit.
// Backpressure: none; bits are taken whenever ena & bit_valid, config writes always accepted.
module seq_detector_multi
    import seqdet_pkg::*;
#(
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int NUM_PAT = DEF_NUM_PAT,
    parameter int CNT_W   = DEF_CNT_W
) (
    input logic     clk,
    input logic     rst_n,
    seqdet_if.slave bus
);

    localparam int LEN_W = len_w(MAX_LEN);
    localparam int SEL_W = sel_w(NUM_PAT);
    localparam logic [LEN_W-1:0] FILL_MAX = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_TOP  = '1;

    typedef struct packed {
        logic [MAX_LEN-1:0] pat;
        logic [LEN_W-1:0]   len;
`ifdef SEQDET_MASK_EN
        logic [MAX_LEN-1:0] mask;
`endif
    } slot_cfg_t;

    slot_cfg_t          slots [NUM_PAT];
    logic [MAX_LEN-1:0] window;
    logic [MAX_LEN-1:0] window_nxt;
    logic [LEN_W-1:0]   fill;
    logic [LEN_W-1:0]   fill_inc;
    logic [LEN_W-1:0]   fill_nxt;
    logic               bit_ok;
    logic               eval;
    logic [NUM_PAT-1:0] raw_hit;
    logic [NUM_PAT-1:0] hits;
    logic               any_hit;
    logic [SEL_W-1:0]   hit_id;

    assign bit_ok = bus.ena & bus.bit_valid;
    // A config write resyncs the stream, so that cycle's bit never completes a match.
    assign eval   = bit_ok & ~bus.cfg_we;

    always_comb begin
        window_nxt = window;
        fill_inc   = fill;
        if (bit_ok) begin
            window_nxt = {window[MAX_LEN-2:0], bus.bit_in};
            fill_inc   = (fill == FILL_MAX) ? fill : fill + 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_PAT; g++) begin : g_slot
        seqdet_cmp #(
            .MAX_LEN (MAX_LEN),
            .LEN_W   (LEN_W)
        ) u_cmp (
            .window (window_nxt),
            .fill   (fill_inc),
            .pat    (slots[g].pat),
            .len    (slots[g].len),
`ifdef SEQDET_MASK_EN
            .mask   (slots[g].mask),
`endif
            .hit    (raw_hit[g])
        );
    end

    assign hits = raw_hit & {NUM_PAT{eval}};

    always_comb begin
        any_hit = |hits;
        hit_id  = '0;
        for (int i = NUM_PAT - 1; i >= 0; i--) begin
            if (hits[i]) begin
                hit_id = SEL_W'(i);
            end
        end
    end

    always_comb begin
        fill_nxt = fill_inc;
        if (bus.cfg_we) begin
            fill_nxt = '0;
        end else if (any_hit && !bus.cfg_overlap) begin
            fill_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
            fill   <= '0;
        end else begin
            window <= window_nxt;
            fill   <= fill_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_PAT; i++) begin
                slots[i].pat <= '0;
                slots[i].len <= '0;
`ifdef SEQDET_MASK_EN
                slots[i].mask <= '1;
`endif
            end
        end else begin
            for (int i = 0; i < NUM_PAT; i++) begin
                if (bus.cfg_we && (bus.cfg_sel == SEL_W'(i))) begin
                    slots[i].pat <= bus.cfg_pat;
                    slots[i].len <= bus.cfg_len;
`ifdef SEQDET_MASK_EN
                    slots[i].mask <= bus.cfg_mask;
`endif
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.match     <= 1'b0;
            bus.match_id  <= '0;
            bus.match_cnt <= '0;
        end else begin
            bus.match <= any_hit;
            if (any_hit) begin
                bus.match_id <= hit_id;
                if (bus.match_cnt != CNT_TOP) begin
                    bus.match_cnt <= bus.match_cnt + 1'b1;
                end
            end
        end
    end

endmodule
